// File: rtl/list_dispatch_arbiter_pkg.sv
// Shared types and helpers for the list dispatch arbiter.
// Holds the FSM encoding, parameter bounds and index width helper.
package list_dispatch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int unsigned N_CONS_MIN = 2;
  localparam int unsigned N_CONS_MAX = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/list_dispatch_arbiter_rr_picker.sv
// Round-robin first-set search over pending requests.
// Search starts one past the last grant and wraps.
module rr_picker
  import list_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned N_CONS = 4,
  localparam int unsigned IW = clog2(N_CONS)
) (
  input  logic [N_CONS-1:0] pending_i,
  input  logic [IW-1:0]     rr_ptr_i,
  output logic              grant_valid_o,
  output logic [IW-1:0]     grant_idx_o
);

  int unsigned j;

  // Walk offsets high to low so the nearest set bit wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    j             = 0;
    for (int unsigned off = N_CONS; off > 0; off--) begin
      j = 32'(rr_ptr_i) + off;
      if (j >= N_CONS) j = j - N_CONS;
      if (pending_i[IW'(j)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/list_dispatch_arbiter.sv
// Shares one req/ack/eol list source among N_CONS consumers,
// one element per consumer request, round-robin order.
module list_dispatch_arbiter
  import list_dispatch_arbiter_pkg::*;
#(
  parameter int unsigned N_CONS = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    ready,
  output logic                    src_req,
  input  logic                    src_ack,
  input  logic                    src_eol,
  input  logic [WIDTH-1:0]        src_value,
  input  logic [N_CONS-1:0]       cons_req,
  output logic [N_CONS-1:0]       cons_ack,
  output logic                    cons_eol,
  output logic [N_CONS*WIDTH-1:0] cons_value
);

  localparam int unsigned IW = clog2(N_CONS);

  state_e                  state_q, state_d;
  logic [N_CONS-1:0]       pending_q, pending_d;
  logic [N_CONS-1:0]       last_req_q;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic                    src_req_q, src_req_d;
  logic [N_CONS-1:0]       cons_ack_q, cons_ack_d;
  logic [N_CONS*WIDTH-1:0] cons_value_q, cons_value_d;

  logic [N_CONS-1:0] req_rise;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;

  assign req_rise   = cons_req & ~last_req_q;
  assign src_req    = src_req_q;
  assign cons_ack   = cons_ack_q;
  assign cons_eol   = src_eol;
  assign cons_value = cons_value_q;

  rr_picker #(
    .N_CONS(N_CONS)
  ) u_pick (
    .pending_i    (pending_q),
    .rr_ptr_i     (rr_ptr_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (src_eol ? '0 : req_rise);
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    src_req_d    = src_req_q;
    cons_ack_d   = '0;
    cons_value_d = cons_value_q;
    unique case (state_q)
      IDLE: begin
        if (src_eol) begin
          pending_d = '0;
        end else if (grant_valid) begin
          pending_d[grant_idx] = 1'b0;
          rr_ptr_d  = grant_idx;
          gnt_d     = grant_idx;
          src_req_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (src_ack) begin
          cons_value_d[gnt_q*WIDTH +: WIDTH] = src_value;
          cons_ack_d[gnt_q] = 1'b1;
          src_req_d = 1'b0;
          state_d   = RECOVER;
        end
      end
      // Keep req low a cycle so the source sees a fresh edge.
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ready) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      last_req_q   <= '0;
      rr_ptr_q     <= IW'(N_CONS - 1);
      gnt_q        <= '0;
      src_req_q    <= 1'b0;
      cons_ack_q   <= '0;
      cons_value_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_req_q   <= cons_req;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      src_req_q    <= src_req_d;
      cons_ack_q   <= cons_ack_d;
      cons_value_q <= cons_value_d;
    end
  end

endmodule

// File: tb/tb_list_dispatch_arbiter.sv
// Directed bench for list_dispatch_arbiter with a
// behavioural list source that acks one cycle after req rises.
module tb_list_dispatch_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           ready = 1'b0;
  logic           src_req;
  logic           src_ack = 1'b0;
  logic           src_eol;
  logic [W-1:0]   src_value = '0;
  logic [N-1:0]   cons_req = '0;
  logic [N-1:0]   cons_ack;
  logic           cons_eol;
  logic [N*W-1:0] cons_value;

  always #5 clock = ~clock;

  list_dispatch_arbiter #(
    .N_CONS(N),
    .WIDTH (W)
  ) dut (
    .clock     (clock),
    .ready     (ready),
    .src_req   (src_req),
    .src_ack   (src_ack),
    .src_eol   (src_eol),
    .src_value (src_value),
    .cons_req  (cons_req),
    .cons_ack  (cons_ack),
    .cons_eol  (cons_eol),
    .cons_value(cons_value)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   s_idx = 0;
  int   s_cnt = 0;
  int   s_cnt_n = 0;
  logic s_load = 1'b0;
  logic s_last = 1'b0;

  assign src_eol = (s_idx >= s_cnt);

  always @(posedge clock) begin
    s_last  <= src_req;
    src_ack <= 1'b0;
    if (s_load) begin
      s_idx <= 0;
      s_cnt <= s_cnt_n;
    end else if (src_req && !s_last && s_idx < s_cnt) begin
      src_ack   <= 1'b1;
      src_value <= W'(s_idx);
      s_idx     <= s_idx + 1;
    end
  end

  typedef struct {
    int idx;
    int val;
    int cyc;
  } ev_t;

  ev_t  evq[$];
  ev_t  ev;
  int   rises = 0;
  int   multi = 0;
  logic rq_prev = 1'b0;
  logic ack_prev = 1'b0;

  always @(negedge clock) begin
    if (cons_ack != 0) begin
      ev.idx = -1;
      ev.val = 0;
      for (int i = 0; i < N; i++) begin
        if (cons_ack[i]) begin
          ev.idx = i;
          ev.val = int'(cons_value[i*W +: W]);
        end
      end
      ev.cyc = cyc;
      evq.push_back(ev);
      if ($countones(cons_ack) != 1 || ack_prev) multi++;
    end
    ack_prev = |cons_ack;
    if (src_req === 1'b1 && !rq_prev) rises++;
    rq_prev = (src_req === 1'b1);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int cnt);
    ready    = 1'b0;
    cons_req = '0;
    s_cnt_n  = cnt;
    s_load   = 1'b1;
    @(negedge clock);
    s_load = 1'b0;
    @(negedge clock);
    ready = 1'b1;
    evq.delete();
    rises = 0;
  endtask

  task automatic pulse(input logic [N-1:0] m, output int t);
    cons_req = cons_req | m;
    @(negedge clock);
    t = cyc;
    cons_req = cons_req & ~m;
  endtask

  task automatic chk_ev(input string tag, input int k,
                        input int idx, input int val);
    if (k < evq.size()) begin
      chk($sformatf("%s_idx%0d", tag, k), evq[k].idx, idx);
      chk($sformatf("%s_val%0d", tag, k), evq[k].val, val);
    end else begin
      chk($sformatf("%s_missing%0d", tag, k), 0, 1);
    end
  endtask

  int te[7];
  int t;
  int n2;

  initial begin
    // single consumer, 6 elements then eol
    do_reset(6);
    chk("rst_src_req", src_req, 0);
    chk("rst_cons_ack", cons_ack, 0);
    chk("rst_cons_value", cons_value, 0);
    for (int j = 0; j < 6; j++) begin
      pulse(4'b0001, te[j]);
      idle(6);
    end
    chk("t1_eol", cons_eol, 1);
    pulse(4'b0001, te[6]);
    idle(8);
    chk("t1_count", evq.size(), 6);
    for (int j = 0; j < 6; j++) begin
      chk_ev("t1", j, 0, j);
      if (j < evq.size())
        chk($sformatf("t1_lat%0d", j), evq[j].cyc - te[j], 3);
    end

    // fairness from reset pointer
    do_reset(8);
    pulse(4'b1111, t);
    idle(20);
    chk("t2a_count", evq.size(), 4);
    for (int j = 0; j < 4; j++) chk_ev("t2a", j, j, j);
    if (evq.size() == 4)
      chk("t2a_spacing", evq[3].cyc - evq[0].cyc, 12);
    evq.delete();
    pulse(4'b1111, t);
    idle(20);
    chk("t2b_count", evq.size(), 4);
    for (int j = 0; j < 4; j++) chk_ev("t2b", j, j, j + 4);
    chk("t2b_values", cons_value, 32'h07060504);

    // rotation: rr_ptr=1 then pending {0,3}
    do_reset(16);
    pulse(4'b0010, t);
    idle(8);
    evq.delete();
    pulse(4'b1001, t);
    idle(12);
    chk("t3_count", evq.size(), 2);
    chk_ev("t3", 0, 3, 1);
    chk_ev("t3", 1, 0, 2);
    chk("t3_hold2", cons_value[23:16], 0);
    chk("t3_hold1", cons_value[15:8], 0);

    // coalesce: consumer 2 toggles while pending
    do_reset(16);
    cons_req = 4'b0101;
    @(negedge clock);
    cons_req = 4'b0000;
    @(negedge clock);
    cons_req[2] = 1'b1;
    @(negedge clock);
    cons_req[2] = 1'b0;
    @(negedge clock);
    cons_req[2] = 1'b1;
    @(negedge clock);
    cons_req[2] = 1'b0;
    idle(14);
    chk("t4_count", evq.size(), 2);
    chk_ev("t4", 0, 0, 0);
    chk_ev("t4", 1, 2, 1);
    n2 = 0;
    foreach (evq[k]) if (evq[k].idx == 2) n2++;
    chk("t4_acks2", n2, 1);

    // eol drops the third request
    do_reset(2);
    pulse(4'b0111, t);
    idle(16);
    chk("t5_count", evq.size(), 2);
    chk_ev("t5", 0, 0, 0);
    chk_ev("t5", 1, 1, 1);
    chk("t5_rises", rises, 2);
    s_cnt_n = 4;
    s_load  = 1'b1;
    @(negedge clock);
    s_load = 1'b0;
    idle(12);
    chk("t5_no_late", evq.size(), 2);
    chk("t5_rises2", rises, 2);

    // reset while src_req is high
    do_reset(16);
    cons_req = 4'b1100;
    @(negedge clock);
    cons_req = 4'b0000;
    @(negedge clock);
    chk("t6_req_hi", src_req, 1);
    ready = 1'b0;
    @(negedge clock);
    ready = 1'b1;
    chk("t6_src_req", src_req, 0);
    chk("t6_cons_ack", cons_ack, 0);
    chk("t6_cons_value", cons_value, 0);
    idle(12);
    chk("t6_no_ack", evq.size(), 0);
    chk("t6_rises", rises, 1);
    pulse(4'b1001, t);
    idle(12);
    chk("t6_count", evq.size(), 2);
    chk_ev("t6", 0, 0, 1);
    chk_ev("t6", 1, 3, 2);

    chk("ack_onehot", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
